// File: rtl/truth_table_sequencer.sv
// Sweeps all 2^N input vectors into a combinational DUT and checks y_in against EXPECTED.
// Optional: define TT_SEQ_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_sequencer #(
  parameter int                  N             = 3,
  parameter int                  SETTLE_CYCLES = 1,
  parameter logic [(2**N)-1:0]   EXPECTED      = 8'h31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         y_in,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0]   RELOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [N-1:0] LAST    = {N{1'b1}};
  localparam logic [N:0]   ERR_MAX = {(N+1){1'b1}};

  state_t       state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N:0]   err_q, err_d;
  logic         fv_q, fv_d;
  logic [N-1:0] ffv_q, ffv_d;
  logic         mism;
  logic         stop;

  assign mism = (y_in != EXPECTED[vec_q]);

`ifdef TT_SEQ_STOP_ON_FAIL_EN
  assign stop = mism || (vec_q == LAST);
`else
  assign stop = (vec_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffv_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CHECK: begin
        if (mism) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffv_d = vec_q;
          end
        end
        // vec stays on the final (or failing) vector once the sweep ends
        if (stop) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = RELOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
    end
  end

  assign vec            = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q & (err_q == '0);
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: sillyfunction model,
// stuck-at-0 and vector-7 faults, SETTLE_CYCLES of 1 and 4.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  int   sel, mode;
  int   n_run, n_fail;

  logic [2:0] v1, v4, f1, f4;
  logic [3:0] e1, e4;
  logic       b1, b4, d1, d4, p1, p4, fv1, fv4;
  logic       y1, y4;
  logic       st1, st4;

  function automatic logic model(input logic [2:0] v, input int m);
    logic y;
    y = (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    if (m == 1) y = 1'b0;
    else if (m == 2 && v == 3'd7) y = ~y;
    return y;
  endfunction

  assign y1  = model(v1, mode);
  assign y4  = model(v4, mode);
  assign st1 = start & (sel == 0);
  assign st4 = start & (sel == 1);

  truth_table_sequencer #(.N(3), .SETTLE_CYCLES(1), .EXPECTED(8'h31)) u_s1 (
    .clk(clk), .reset(reset), .start(st1), .y_in(y1),
    .vec(v1), .busy(b1), .done(d1), .pass(p1), .err_count(e1),
    .fail_valid(fv1), .first_fail_vec(f1)
  );

  truth_table_sequencer #(.N(3), .SETTLE_CYCLES(4), .EXPECTED(8'h31)) u_s4 (
    .clk(clk), .reset(reset), .start(st4), .y_in(y4),
    .vec(v4), .busy(b4), .done(d4), .pass(p4), .err_count(e4),
    .fail_valid(fv4), .first_fail_vec(f4)
  );

  logic [2:0] vs, fs;
  logic [3:0] es;
  logic       bs, ds, ps, fvs;
  assign vs  = (sel == 1) ? v4  : v1;
  assign fs  = (sel == 1) ? f4  : f1;
  assign es  = (sel == 1) ? e4  : e1;
  assign bs  = (sel == 1) ? b4  : b1;
  assign ds  = (sel == 1) ? d4  : d1;
  assign ps  = (sel == 1) ? p4  : p1;
  assign fvs = (sel == 1) ? fv4 : fv1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sweep(input int sc, input bit chk_vec, input int poke,
                       output int lat);
    int exp_v;
    bit poked;
    poked = 1'b0;
    lat   = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (chk_vec) begin
        exp_v = k / (sc + 1);
        if (exp_v > 7) exp_v = 7;
        check($sformatf("vec@%0d", k), 32'(vs), 32'(exp_v));
        if (!ds) check($sformatf("busy@%0d", k), 32'(bs), 32'd1);
      end
      if (ds) begin
        lat = k;
        break;
      end
      if (!poked && poke >= 0 && int'(vs) == poke) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    if (lat < 0) check("timeout_done", 32'(ds), 32'd1);
  endtask

  task automatic chk_result(input string t, input int lat, input int elat,
                            input int ev, input int ee, input int efv,
                            input int eff, input int ep);
    check({t, "_lat"},  32'(lat), 32'(elat));
    check({t, "_vec"},  32'(vs),  32'(ev));
    check({t, "_err"},  32'(es),  32'(ee));
    check({t, "_fv"},   32'(fvs), 32'(efv));
    check({t, "_ffv"},  32'(fs),  32'(eff));
    check({t, "_pass"}, 32'(ps),  32'(ep));
    check({t, "_busy"}, 32'(bs),  32'd0);
  endtask

  initial begin
    int lat;
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    sel    = 0;
    mode   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec",  32'(v1),  32'd0);
    check("rst_busy", 32'(b1),  32'd0);
    check("rst_done", 32'(d1),  32'd0);
    check("rst_pass", 32'(p1),  32'd0);
    check("rst_err",  32'(e1),  32'd0);
    check("rst_fv",   32'(fv1), 32'd0);
    check("rst_ffv",  32'(f1),  32'd0);
    check("rst4_done", 32'(d4), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    sweep(1, 1'b1, -1, lat);
    chk_result("good", lat, 16, 7, 0, 0, 0, 1);

    mode = 1;
    sweep(1, 1'b0, -1, lat);
`ifdef TT_SEQ_STOP_ON_FAIL_EN
    chk_result("stuck", lat, 2, 0, 1, 1, 0, 0);
`else
    chk_result("stuck", lat, 16, 7, 3, 1, 0, 0);
`endif

    sel  = 1;
    mode = 0;
    sweep(4, 1'b1, -1, lat);
    chk_result("settle4", lat, 40, 7, 0, 0, 0, 1);
    sel = 0;

    sweep(1, 1'b0, 3, lat);
    chk_result("poke", lat, 16, 7, 0, 0, 0, 1);
    sweep(1, 1'b0, -1, lat);
    chk_result("rerun", lat, 16, 7, 0, 0, 0, 1);

    mode = 2;
    sweep(1, 1'b0, -1, lat);
    chk_result("inv7", lat, 16, 7, 1, 1, 7, 0);
    mode = 0;
    sweep(1, 1'b0, -1, lat);
    chk_result("clear", lat, 16, 7, 0, 0, 0, 1);

`ifdef TT_SEQ_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 1;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && v1 != 3'd5; k++) begin
      @(posedge clk); #1;
    end
    check("mid_vec5", 32'(v1), 32'd5);
`ifndef TT_SEQ_STOP_ON_FAIL_EN
    check("mid_err", 32'(e1), 32'd2);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_vec",  32'(v1),  32'd0);
    check("midrst_busy", 32'(b1),  32'd0);
    check("midrst_err",  32'(e1),  32'd0);
    check("midrst_fv",   32'(fv1), 32'd0);
    check("midrst_done", 32'(d1),  32'd0);
    reset = 1'b0;
    mode  = 0;
    @(posedge clk); #1;

    sweep(1, 1'b0, -1, lat);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rs_done", 32'(d1), 32'd0);
    check("rs_busy", 32'(b1), 32'd0);
    @(posedge clk); #1;
    check("rs_idle_busy", 32'(b1), 32'd0);
    check("rs_idle_vec",  32'(v1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
